irrigation_scheduler: RTL and testbench
=======================================

Name: irrigation_scheduler

Overview:
Sequences the shared pump and the two irrigation valves, sprinkler (aspersao) and drip (gotejamento). It takes the sprinkler and drip request lines produced by the irrigation decision logic and grants at most one of them at a time. Each granted cycle runs as a timed sequence: valve settle, pump run, pump stop, rest. Timing is counted in ticks from the clock divider. A tank-critical level or a sensor error aborts the cycle immediately.

Parameters:
VALVE_TICKS, 2, ticks the valve is open before the pump starts (1..255)
MIN_RUN, 5, minimum pump-on ticks, unless an abort occurs (1..255, ≤ MAX_RUN)
MAX_RUN, 60, maximum pump-on ticks per cycle (1..255)
STOP_TICKS, 1, ticks the valve stays open after the pump stops (1..255)
REST_TICKS, 10, ticks with everything off before a new grant (1..255)

Ports:
clock  in  1  system clock; single clock domain
Rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle enable pulse from the clock divider
req_asp  in  1  sprinkler irrigation request (level)
req_got  in  1  drip irrigation request (level)
erro  in  1  sensor-inconsistency error
nv_critico  in  1  tank level critical
bomba  out  1  pump enable
valv_asp  out  1  sprinkler valve open
valv_got  out  1  drip valve open
busy  out  1  high in any state other than IDLE
estado  out  3  current state code, for display/debug
abort_flag  out  1  sticky; set by an abort, cleared only by Rst

Behaviour:
- Reset: state IDLE; bomba, valv_asp, valv_got, busy, abort_flag = 0; timer = 0; last_grant = GOT, so the first tie goes to asp.
- Reset mid-operation: every output is 0 after the Rst edge, with no stop sequence.
- Timer: 8-bit. Cleared on every state entry. Incremented only on cycles where tick=1.
- Timed exit: a state with limit N exits on the clock edge where tick=1 and the timer equals N-1, i.e. on the Nth tick after entry.
- All outputs are registered and decoded from the state plus the grant register.
- block = erro | nv_critico.
- IDLE (code 0): all outputs off.
  - If block=0 and at least one request is high, latch the grant and go to OPEN on the next edge. No tick is needed.
  - Both requests high: grant the requester that is not last_grant, then update last_grant.
  - If block=1, no grant is made.
- OPEN (code 1): the granted valve is on; pump off.
  - Go to RUN after VALVE_TICKS ticks.
  - block=1: go to STOP.
- RUN (code 2): pump and granted valve on.
  - Exit to STOP when the timer reaches MAX_RUN.
  - Exit to STOP when the granted request is low and the timer is ≥ MIN_RUN; this is checked on tick cycles.
  - A request that drops before MIN_RUN is ignored until MIN_RUN has been reached.
- STOP (code 3): pump off on entry; granted valve still on. Go to REST after STOP_TICKS ticks.
- REST (code 4): all outputs off. Go to IDLE after REST_TICKS ticks. Requests are ignored.
- Abort: block=1 in OPEN or RUN.
  - Next state is STOP, so bomba drops one edge later.
  - abort_flag is set, and MIN_RUN is overridden.
  - In STOP and REST, block has no effect.
- Simultaneous events: abort and MAX_RUN timeout on the same edge resolve as abort (flag set). A request drop coinciding with an abort is handled as an abort.
- Grant is held from IDLE exit through REST. A change in the other request never preempts the current cycle.
- bomba=1 only in RUN. valv_asp and valv_got are never both 1.

Optional Feature:
Macro SCHED_CYCLE_COUNT_EN.
- Defined: adds output ciclos [7:0], a count of RUN exits (normal or abort).
  - Saturates at 255. Reset to 0 by Rst.
  - An abort exit increments it too.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package irrigation_pkg holds:
  - state encoding IDLE=0, OPEN=1, RUN=2, STOP=3, REST=4;
  - grant type (ASP, GOT);
  - timer width constant (8).
- One sub-module, tick_timer: clear, tick enable, 8-bit count, and a compare-to-limit output giving "done on this tick". It is reused for every state.

Test Plan:
(Bench parameters VALVE_TICKS=2, MIN_RUN=3, MAX_RUN=6, STOP_TICKS=1, REST_TICKS=4; tick=1 every cycle.)
- Single request: req_asp held high → OPEN for 2 cycles, bomba=1 with valv_asp for 6 cycles (MAX_RUN), STOP for 1 cycle with valv_asp=1 and bomba=0, REST for 4 cycles, then a new grant.
- Round-robin: req_asp and req_got both high from reset → asp granted first, got granted after REST, then asp again; the valves never overlap.
- Minimum run: req_got pulsed high for 1 cycle → RUN lasts exactly 3 ticks, then STOP.
- Abort: nv_critico raised on the 2nd RUN cycle → bomba=0 on the following edge, valve on for 1 STOP cycle, abort_flag=1 until Rst.
- Blocked idle: erro=1 with req_asp=1 → stays in IDLE, busy=0; on clearing erro, OPEN follows on the next edge.
- Reset and counter: Rst asserted in RUN → all outputs 0 on the next edge, estado=0. With SCHED_CYCLE_COUNT_EN, ciclos increments once per RUN exit and saturates after 255 cycles.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared state codes, grant type and timer width for the irrigation scheduler.
package irrigation_pkg;

  localparam int TIMER_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OPEN = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_STOP = 3'd3;
  localparam logic [2:0] ST_REST = 3'd4;

  typedef enum logic {
    GR_ASP = 1'b0,
    GR_GOT = 1'b1
  } grant_t;

  function automatic grant_t other_grant(input grant_t g);
    return (g == GR_ASP) ? GR_GOT : GR_ASP;
  endfunction

  // The granted valve stays open from settle through the post-stop drain.
  function automatic logic valve_phase(input logic [2:0] st);
    return (st == ST_OPEN) || (st == ST_RUN) || (st == ST_STOP);
  endfunction

endpackage

// File: rtl/irrigation_scheduler_tick_timer.sv
// Tick counter with clear; done_o flags the tick that completes limit_i ticks.
// done_o is combinational from the current count and the tick enable.
module tick_timer
  import irrigation_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = en_i && (count_q == (limit_i - W'(1)));

endmodule

// File: rtl/irrigation_scheduler.sv
// Pump/valve sequencer: grants one of two requests round-robin, then runs OPEN-RUN-STOP-REST.
// Outputs are registered from next state; SCHED_CYCLE_COUNT_EN adds the ciclos RUN-exit counter.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int VALVE_TICKS = 2,
  parameter int MIN_RUN     = 5,
  parameter int MAX_RUN     = 60,
  parameter int STOP_TICKS  = 1,
  parameter int REST_TICKS  = 10
) (
  input  logic       clock,
  input  logic       Rst,
  input  logic       tick,
  input  logic       req_asp,
  input  logic       req_got,
  input  logic       erro,
  input  logic       nv_critico,
  output logic       bomba,
  output logic       valv_asp,
  output logic       valv_got,
  output logic       busy,
  output logic [2:0] estado,
`ifdef SCHED_CYCLE_COUNT_EN
  output logic       abort_flag,
  output logic [7:0] ciclos
`else
  output logic       abort_flag
`endif
);

  logic [2:0]         state_q, state_d;
  grant_t             grant_q, grant_d;
  grant_t             last_q, last_d;
  logic               abort_q, abort_d;
  logic               bomba_q, valv_asp_q, valv_got_q, busy_q;
  logic [TIMER_W-1:0] limit;
  logic [TIMER_W-1:0] count;
  logic               done;
  logic               blk;
  logic               req_gr;
  logic               min_met;
  logic               run_exit;

  tick_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk_i   (clock),
    .rst_i   (Rst),
    .clr_i   (state_d != state_q),
    .en_i    (tick),
    .limit_i (limit),
    .count_o (count),
    .done_o  (done)
  );

  always_comb begin
    limit = TIMER_W'(1);
    case (state_q)
      ST_OPEN: limit = TIMER_W'(VALVE_TICKS);
      ST_RUN:  limit = TIMER_W'(MAX_RUN);
      ST_STOP: limit = TIMER_W'(STOP_TICKS);
      ST_REST: limit = TIMER_W'(REST_TICKS);
      default: limit = TIMER_W'(1);
    endcase
  end

  assign blk    = erro | nv_critico;
  assign req_gr = (grant_q == GR_ASP) ? req_asp : req_got;
  // The tick being counted now is the MIN_RUN-th one once count reaches MIN_RUN-1.
  assign min_met = count >= TIMER_W'(MIN_RUN - 1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (!blk && (req_asp || req_got)) begin
          if (req_asp && req_got) begin
            grant_d = other_grant(last_q);
          end else begin
            grant_d = req_asp ? GR_ASP : GR_GOT;
          end
          last_d  = grant_d;
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (blk) begin
          abort_d = 1'b1;
          state_d = ST_STOP;
        end else if (done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (blk) begin
          abort_d = 1'b1;
          state_d = ST_STOP;
        end else if (done) begin
          state_d = ST_STOP;
        end else if (tick && !req_gr && min_met) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (done) begin
          state_d = ST_REST;
        end
      end
      ST_REST: begin
        if (done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign run_exit = (state_q == ST_RUN) && (state_d != ST_RUN);

  always_ff @(posedge clock) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= GR_GOT;
      last_q     <= GR_GOT;
      abort_q    <= 1'b0;
      bomba_q    <= 1'b0;
      valv_asp_q <= 1'b0;
      valv_got_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      abort_q    <= abort_d;
      bomba_q    <= (state_d == ST_RUN);
      valv_asp_q <= valve_phase(state_d) && (grant_d == GR_ASP);
      valv_got_q <= valve_phase(state_d) && (grant_d == GR_GOT);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign bomba      = bomba_q;
  assign valv_asp   = valv_asp_q;
  assign valv_got   = valv_got_q;
  assign busy       = busy_q;
  assign estado     = state_q;
  assign abort_flag = abort_q;

`ifdef SCHED_CYCLE_COUNT_EN
  logic [7:0] ciclos_q;

  always_ff @(posedge clock) begin
    if (Rst) begin
      ciclos_q <= 8'd0;
    end else if (run_exit && (ciclos_q != 8'hFF)) begin
      ciclos_q <= ciclos_q + 8'd1;
    end
  end

  assign ciclos = ciclos_q;
`endif

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed and random checks of irrigation_scheduler against a tick-countdown reference model.
module tb_irrigation_scheduler;

  localparam int VT   = 2;
  localparam int MINR = 3;
  localparam int MAXR = 6;
  localparam int ST   = 1;
  localparam int RT   = 4;

  logic       clock = 1'b0;
  logic       Rst, tick, req_asp, req_got, erro, nv_critico;
  logic       bomba, valv_asp, valv_got, busy, abort_flag;
  logic [2:0] estado;
`ifdef SCHED_CYCLE_COUNT_EN
  logic [7:0] ciclos;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0..4 = idle/open/run/stop/rest, countdown of remaining ticks.
  int m_ph, m_left, m_ran, m_cyc;
  bit m_grant, m_last, m_abort;

  always #5 clock = ~clock;

  irrigation_scheduler #(
    .VALVE_TICKS (VT),
    .MIN_RUN     (MINR),
    .MAX_RUN     (MAXR),
    .STOP_TICKS  (ST),
    .REST_TICKS  (RT)
  ) dut (
    .clock      (clock),
    .Rst        (Rst),
    .tick       (tick),
    .req_asp    (req_asp),
    .req_got    (req_got),
    .erro       (erro),
    .nv_critico (nv_critico),
    .bomba      (bomba),
    .valv_asp   (valv_asp),
    .valv_got   (valv_got),
    .busy       (busy),
    .estado     (estado),
`ifdef SCHED_CYCLE_COUNT_EN
    .abort_flag (abort_flag),
    .ciclos     (ciclos)
`else
    .abort_flag (abort_flag)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bomba, valv_asp, valv_got, busy, estado, abort_flag};
  endfunction

  function automatic logic [7:0] m_exp();
    logic on;
    on = (m_ph >= 1) && (m_ph <= 3);
    return {m_ph == 2, on && !m_grant, on && m_grant, m_ph != 0, 3'(m_ph), m_abort};
  endfunction

  task automatic m_to_stop();
    m_ph   = 3;
    m_left = ST;
  endtask

  task automatic model_edge();
    bit blk, rg;
    blk = erro | nv_critico;
    if (Rst) begin
      m_ph = 0; m_left = 0; m_ran = 0; m_cyc = 0;
      m_grant = 1'b1; m_last = 1'b1; m_abort = 1'b0;
      return;
    end
    rg = m_grant ? req_got : req_asp;
    case (m_ph)
      0: if (!blk && (req_asp || req_got)) begin
        m_grant = (req_asp && req_got) ? !m_last : !req_asp;
        m_last  = m_grant;
        m_ph    = 1;
        m_left  = VT;
      end
      1: if (blk) begin
        m_abort = 1'b1;
        m_to_stop();
      end else if (tick) begin
        m_left--;
        if (m_left == 0) begin m_ph = 2; m_ran = 0; end
      end
      2: if (blk) begin
        m_abort = 1'b1;
        m_to_stop();
        if (m_cyc < 255) m_cyc++;
      end else if (tick) begin
        m_ran++;
        if (m_ran == MAXR || (!rg && m_ran >= MINR)) begin
          m_to_stop();
          if (m_cyc < 255) m_cyc++;
        end
      end
      3: if (tick) begin
        m_left--;
        if (m_left == 0) begin m_ph = 4; m_left = RT; end
      end
      default: if (tick) begin
        m_left--;
        if (m_left == 0) m_ph = 0;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("cycle", 32'(outs()), 32'(m_exp()));
`ifdef SCHED_CYCLE_COUNT_EN
    check("ciclos", 32'(ciclos), 32'(m_cyc));
`endif
  endtask

  task automatic do_reset();
    Rst = 1'b1; tick = 1'b1; req_asp = 1'b0; req_got = 1'b0; erro = 1'b0; nv_critico = 1'b0;
    step();
    step();
    Rst = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (bomba !== 1'b1 && n < 40) begin step(); n++; end
    check(tag, 32'(bomba), 32'(1));
  endtask

  task automatic count_state(input logic [2:0] st, output int len);
    len = 0;
    while (estado === st && len < 40) begin len++; step(); end
  endtask

  initial begin
    int len, ng, overlap;
    logic [2:0] gseq, prev;

    // Single held request: full sequence and re-grant
    do_reset();
    check("reset_outs", 32'(outs()), 32'(8'h00));
    req_asp = 1'b1;
    wait_run("t1_wait_run");
    count_state(3'd2, len);
    check("t1_run_len", 32'(len), 32'(MAXR));
    check("t1_stop", 32'({estado, valv_asp, bomba}), 32'({3'd3, 1'b1, 1'b0}));
    step();
    count_state(3'd4, len);
    check("t1_rest_len", 32'(len), 32'(RT));
    step();
    check("t1_regrant", 32'({estado, valv_asp}), 32'({3'd1, 1'b1}));

    // Round-robin with both requests held
    do_reset();
    req_asp = 1'b1; req_got = 1'b1;
    ng = 0; overlap = 0; gseq = 'x; prev = 3'd0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (valv_asp && valv_got) overlap++;
      if (estado == 3'd1 && prev != 3'd1) begin
        if (ng < 3) gseq[ng] = valv_got;
        ng++;
      end
      prev = estado;
    end
    check("t2_order", 32'(gseq), 32'(3'b010));
    check("t2_overlap", 32'(overlap), 32'(0));

    // Minimum run after a one-cycle request pulse
    do_reset();
    req_got = 1'b1;
    step();
    req_got = 1'b0;
    wait_run("t3_wait_run");
    count_state(3'd2, len);
    check("t3_run_len", 32'(len), 32'(MINR));
    check("t3_stop", 32'({estado, valv_got, bomba}), 32'({3'd3, 1'b1, 1'b0}));

    // Abort on the second RUN cycle; flag is sticky until Rst
    do_reset();
    req_asp = 1'b1;
    wait_run("t4_wait_run");
    step();
    check("t4_run2", 32'(bomba), 32'(1));
    nv_critico = 1'b1;
    step();
    check("t4_abort", 32'({bomba, valv_asp, estado, abort_flag}), 32'({1'b0, 1'b1, 3'd3, 1'b1}));
    nv_critico = 1'b0;
    step();
    check("t4_rest", 32'({valv_asp, estado}), 32'({1'b0, 3'd4}));
    repeat (30) step();
    check("t4_sticky", 32'(abort_flag), 32'(1));
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("t4_cleared", 32'(abort_flag), 32'(0));

    // Blocked idle, then grant on the edge after the block clears
    do_reset();
    erro = 1'b1; req_asp = 1'b1;
    repeat (5) step();
    check("t5_blocked", 32'({estado, busy}), 32'({3'd0, 1'b0}));
    erro = 1'b0;
    step();
    check("t5_open", 32'(estado), 32'(3'd1));

    // Reset while running
    do_reset();
    req_asp = 1'b1;
    wait_run("t6_wait_run");
    step();
    Rst = 1'b1;
    step();
    check("t6_rst_run", 32'(outs()), 32'(8'h00));
    Rst = 1'b0;

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      Rst        = ($urandom_range(0, 299) == 0);
      tick       = ($urandom_range(0, 3) != 0);
      erro       = ($urandom_range(0, 49) == 0);
      nv_critico = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) req_asp = ~req_asp;
      if ($urandom_range(0, 7) == 0) req_got = ~req_got;
      step();
    end

`ifdef SCHED_CYCLE_COUNT_EN
    do_reset();
    req_asp = 1'b1; req_got = 1'b1;
    repeat (3700) step();
    check("ciclos_sat", 32'(ciclos), 32'(8'd255));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
